// File: rtl/branch_cmp_pipe_if.sv
// branch_cmp_pipe_if: operand/control inputs and result/counter outputs of the compare pipe
interface branch_cmp_pipe_if #(parameter int WIDTH = 32, parameter int CNT_W = 16);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic             clr_cnt;
  logic [WIDTH-1:0] D1;
  logic [WIDTH-1:0] D2;
  logic [3:0]       CMP_CTR;
  logic             out_valid;
  logic             RES_CMP;
  logic [CNT_W-1:0] taken_cnt;
  modport master (output in_valid, stall, flush, clr_cnt, D1, D2, CMP_CTR,
                  input  out_valid, RES_CMP, taken_cnt);
  modport slave  (input  in_valid, stall, flush, clr_cnt, D1, D2, CMP_CTR,
                  output out_valid, RES_CMP, taken_cnt);
endinterface

// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: 1- or 2-stage branch condition evaluator with saturating taken counter
module branch_cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst_n,
  branch_cmp_pipe_if.slave bus
);
  function automatic logic cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [3:0] c);
    logic n, z;
    n = a[WIDTH-1];
    z = (a == '0);
    case (c)
      4'b0110: return a == b;
      4'b0001: return a != b;
      4'b0010: return !n;
      4'b0011: return !n && !z;
      4'b0100: return n || z;
      4'b0101: return n;
      4'b1000: return $signed(a) <  $signed(b);
      4'b1001: return $signed(a) >= $signed(b);
      4'b1010: return a <  b;
      4'b1011: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  logic             s_v;
  logic [WIDTH-1:0] s_d1, s_d2;
  logic [3:0]       s_ctr;
  // Evaluation source: raw inputs for one stage, registered operands for two
  generate
    if (STAGES == 2) begin : g_two
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s_v   <= 1'b0;
          s_d1  <= '0;
          s_d2  <= '0;
          s_ctr <= '0;
        end else if (bus.flush) begin
          s_v <= 1'b0;
        end else if (!bus.stall) begin
          s_v   <= bus.in_valid;
          s_d1  <= bus.D1;
          s_d2  <= bus.D2;
          s_ctr <= bus.CMP_CTR;
        end
    end else begin : g_one
      assign s_v   = bus.in_valid;
      assign s_d1  = bus.D1;
      assign s_d2  = bus.D2;
      assign s_ctr = bus.CMP_CTR;
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.RES_CMP   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.RES_CMP   <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid <= s_v;
      bus.RES_CMP   <= s_v && cmp(s_d1, s_d2, s_ctr);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.taken_cnt <= '0;
    else if (bus.clr_cnt) bus.taken_cnt <= '0;
    else if (bus.out_valid && bus.RES_CMP && !bus.stall && !bus.flush && !(&bus.taken_cnt))
      bus.taken_cnt <= bus.taken_cnt + 1'b1;
endmodule

// File: tb/tb_branch_cmp_pipe.sv
// tb_branch_cmp_pipe: directed checks on 1-stage/32-bit, 2-stage/4-bit-counter and 8-bit instances
module tb_branch_cmp_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  branch_cmp_pipe_if #(.WIDTH(32), .CNT_W(16)) b1 ();
  branch_cmp_pipe_if #(.WIDTH(32), .CNT_W(4))  b2 ();
  branch_cmp_pipe_if #(.WIDTH(8),  .CNT_W(16)) b3 ();
  branch_cmp_pipe #(.WIDTH(32), .STAGES(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  branch_cmp_pipe #(.WIDTH(32), .STAGES(2), .CNT_W(4))  u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  branch_cmp_pipe #(.WIDTH(8),  .STAGES(1), .CNT_W(16)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  logic [31:0] t_d1  [10] = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0,
                              32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
  logic [31:0] t_d2  [10] = '{32'd5, 32'd5, 32'd9, 32'd0, 32'd7,
                              32'd0, 32'd0, 32'd1, 32'd1, 32'd3};
  logic [3:0]  t_ctr [10] = '{4'b0110, 4'b0001, 4'b0010, 4'b0010, 4'b0011,
                              4'b0100, 4'b0101, 4'b1001, 4'b1011, 4'b0111};
  logic        t_exp [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    {b1.in_valid, b1.stall, b1.flush, b1.clr_cnt, b1.D1, b1.D2, b1.CMP_CTR} = '0;
    {b2.in_valid, b2.stall, b2.flush, b2.clr_cnt, b2.D1, b2.D2, b2.CMP_CTR} = '0;
    {b3.in_valid, b3.stall, b3.flush, b3.clr_cnt, b3.D1, b3.D2, b3.CMP_CTR} = '0;
    #12;
    chk("rst_ov1", b1.out_valid, 0);
    chk("rst_res1", b1.RES_CMP, 0);
    chk("rst_cnt1", b1.taken_cnt, 0);
    chk("rst_ov2", b2.out_valid, 0);
    chk("rst_cnt2", b2.taken_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    // Signed vs unsigned less-than on the same operands
    b1.in_valid = 1; b1.D1 = 32'h8000_0000; b1.D2 = 32'd1; b1.CMP_CTR = 4'b1000;
    @(negedge clk);
    chk("slt_ov", b1.out_valid, 1);
    chk("slt_res", b1.RES_CMP, 1);
    b1.CMP_CTR = 4'b1010;
    @(negedge clk);
    chk("ult_ov", b1.out_valid, 1);
    chk("ult_res", b1.RES_CMP, 0);
    b1.in_valid = 0;
    @(negedge clk);
    chk("bubble_ov", b1.out_valid, 0);
    chk("bubble_res", b1.RES_CMP, 0);
    chk("cnt1_after2", b1.taken_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      b1.in_valid = 1; b1.D1 = t_d1[i]; b1.D2 = t_d2[i]; b1.CMP_CTR = t_ctr[i];
      @(negedge clk);
      chk($sformatf("tbl%0d_ov", i), b1.out_valid, 1);
      chk($sformatf("tbl%0d_res", i), b1.RES_CMP, t_exp[i]);
    end
    b1.in_valid = 0;
    // 8-bit zero compares use bit 7 as sign
    b3.in_valid = 1; b3.D1 = 8'h7F; b3.D2 = 8'hFF; b3.CMP_CTR = 4'b0011;
    @(negedge clk) chk("w8_gtz", b3.RES_CMP, 1);
    b3.D1 = 8'hFF; b3.CMP_CTR = 4'b0101;
    @(negedge clk) chk("w8_ltz", b3.RES_CMP, 1);
    b3.D1 = 8'h80; b3.CMP_CTR = 4'b0010;
    @(negedge clk) chk("w8_gez_neg", b3.RES_CMP, 0);
    b3.D1 = 8'h00; b3.CMP_CTR = 4'b1111;
    @(negedge clk) chk("w8_undef", b3.RES_CMP, 0);
    b3.in_valid = 0;
    // Two-stage latency and throughput
    b2.in_valid = 1; b2.D1 = 5; b2.D2 = 5; b2.CMP_CTR = 4'b0110;
    @(negedge clk) chk("s2_lat_ov", b2.out_valid, 0);
    b2.CMP_CTR = 4'b0001;
    @(negedge clk) chk("s2_eq_ov", b2.out_valid, 1);
    chk("s2_eq_res", b2.RES_CMP, 1);
    b2.D1 = 0; b2.CMP_CTR = 4'b0011;
    @(negedge clk) chk("s2_ne_ov", b2.out_valid, 1);
    chk("s2_ne_res", b2.RES_CMP, 0);
    b2.in_valid = 0;
    @(negedge clk) chk("s2_gtz_ov", b2.out_valid, 1);
    chk("s2_gtz_res", b2.RES_CMP, 0);
    @(negedge clk) chk("s2_drain_ov", b2.out_valid, 0);
    chk("s2_cnt", b2.taken_cnt, 1);
    // Stall with two ops in flight, then flush while still stalled
    b2.in_valid = 1; b2.D1 = 7; b2.D2 = 7; b2.CMP_CTR = 4'b0110;
    @(negedge clk) b2.D2 = 8;
    @(negedge clk) b2.in_valid = 0; b2.stall = 1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_ov", i), b2.out_valid, 1);
      chk($sformatf("stall%0d_res", i), b2.RES_CMP, 1);
      @(negedge clk);
    end
    chk("stall_end_ov", b2.out_valid, 1);
    chk("stall_cnt", b2.taken_cnt, 1);
    b2.flush = 1;
    @(negedge clk) chk("flush_ov", b2.out_valid, 0);
    chk("flush_res", b2.RES_CMP, 0);
    chk("flush_cnt", b2.taken_cnt, 1);
    b2.flush = 0; b2.stall = 0;
    @(negedge clk) chk("flush_stagea_ov", b2.out_valid, 0);
    @(negedge clk) chk("flush_stagea_ov2", b2.out_valid, 0);
    b2.clr_cnt = 1;
    @(negedge clk) chk("clr_cnt", b2.taken_cnt, 0);
    b2.clr_cnt = 0;
    // Counter saturation at 15 with 17 taken retires
    b2.in_valid = 1; b2.D1 = 1; b2.D2 = 1; b2.CMP_CTR = 4'b0110;
    repeat (17) @(negedge clk);
    b2.in_valid = 0;
    repeat (3) @(negedge clk);
    chk("sat_cnt", b2.taken_cnt, 15);
    b2.clr_cnt = 1;
    @(negedge clk) chk("sat_clr", b2.taken_cnt, 0);
    b2.clr_cnt = 0; b2.in_valid = 1;
    @(negedge clk) b2.in_valid = 0;
    @(negedge clk) chk("clr_race_ov", b2.out_valid, 1);
    chk("clr_race_res", b2.RES_CMP, 1);
    b2.clr_cnt = 1;
    @(negedge clk) chk("clr_race_cnt", b2.taken_cnt, 0);
    b2.clr_cnt = 0;
    // Asynchronous reset mid-operation
    b2.in_valid = 1;
    repeat (4) @(negedge clk);
    chk("pre_rst_ov", b2.out_valid, 1);
    chk("pre_rst_cnt", b2.taken_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", b2.out_valid, 0);
    chk("arst_res", b2.RES_CMP, 0);
    chk("arst_cnt", b2.taken_cnt, 0);
    chk("arst_cnt1", b1.taken_cnt, 0);
    b2.in_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("post_rst_ov", b2.out_valid, 0);
    b2.in_valid = 1; b2.CMP_CTR = 4'b0001; b2.D1 = 3; b2.D2 = 4;
    @(negedge clk) chk("post_rst_lat", b2.out_valid, 0);
    b2.in_valid = 0;
    @(negedge clk) chk("post_rst_ov2", b2.out_valid, 1);
    chk("post_rst_res", b2.RES_CMP, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_cmp_pipe.md
BRANCH_CMP_PIPE -- requirements
Module: branch_cmp_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter STAGES, default 1, giving the pipeline depth (legal values 1 or 2).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the taken-branch counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 in_valid  input  1  D1, D2 and CMP_CTR are valid this cycle.
REQ-007 stall  input  1  hold every pipeline register; no acceptance.
REQ-008 flush  input  1  kill all in-flight and incoming compares.
REQ-009 clr_cnt  input  1  synchronous clear of taken_cnt.
REQ-010 D1  input  WIDTH  first operand.
REQ-011 D2  input  WIDTH  second operand.
REQ-012 CMP_CTR  input  4  compare operation select.
REQ-013 out_valid  output  1  RES_CMP carries a valid result.
REQ-014 RES_CMP  output  1  branch-taken result; 0 whenever out_valid=0.
REQ-015 taken_cnt  output  CNT_W  saturating count of retired taken results.

Function
REQ-016 CMP_CTR encoding SHALL be: 0110 D1==D2; 0001 D1!=D2; 0010 signed D1>=0; 0011 signed D1>0; 0100 signed D1<=0; 0101 signed D1<0; 1000 signed D1<D2; 1001 signed D1>=D2; 1010 unsigned D1<D2; 1011 unsigned D1>=D2; all other codes result 0.
REQ-017 Zero compares SHALL use bit WIDTH-1 of D1 as the sign and ignore D2.
REQ-018 An input SHALL be accepted on a rising edge when in_valid=1, stall=0, flush=0.
REQ-019 With STAGES=1, the compare SHALL be evaluated on the accepted inputs and registered, giving out_valid/RES_CMP exactly 1 cycle after acceptance.
REQ-020 With STAGES=2, stage A SHALL register D1, D2, CMP_CTR and a valid bit; stage B SHALL evaluate from stage A and register result plus valid, giving latency 2.
REQ-021 When stall=1 and flush=0, every stage register including out_valid and RES_CMP SHALL hold its value.
REQ-022 When in_valid=0 and stall=0, the first stage SHALL load valid=0 (bubble) and bubbles SHALL advance like data.
REQ-023 flush=1 SHALL clear every stage valid bit and RES_CMP on the next edge, take priority over stall and in_valid, and discard the same-cycle input.
REQ-024 Back-to-back accepted inputs SHALL produce results on consecutive cycles (throughput 1/cycle).
REQ-025 A result SHALL retire on a cycle with out_valid=1, stall=0, flush=0.
REQ-026 taken_cnt SHALL increment by 1 when a retiring result has RES_CMP=1.
REQ-027 taken_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 clr_cnt=1 SHALL load taken_cnt=0 on the next edge, overriding a simultaneous increment.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force all valid bits, out_valid, RES_CMP and taken_cnt to 0; stored operands SHALL clear to 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight compares; after rst_n rises, the first acceptance SHALL be the next qualifying edge.

Verification
REQ-031 STAGES=1, WIDTH=32: D1=0x80000000, D2=0x00000001, CMP_CTR=1000 -> next cycle out_valid=1, RES_CMP=1; same operands with 1010 -> RES_CMP=0.
REQ-032 STAGES=2: accept EQ 5==5, NE 5!=5, GTZ D1=0 on 3 consecutive cycles -> RES_CMP sequence 1,0,0 with out_valid high on cycles 2,3,4.
REQ-033 STAGES=2: two ops in flight, stall for 3 cycles then flush with stall still high -> outputs frozen during stall; out_valid=0 after the flush edge; taken_cnt unchanged.
REQ-034 CNT_W=4: retire 17 taken results -> taken_cnt reaches 15 and holds; clr_cnt together with a taken retire -> taken_cnt=0.
REQ-035 Assert rst_n=0 between clock edges with out_valid=1 -> out_valid, RES_CMP and taken_cnt go to 0 before the next edge.
REQ-036 WIDTH=8: D1=0x7F, CMP_CTR=0011 -> 1; D1=0xFF with 0101 -> 1; undefined code 1111 -> 0.
